// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_pkg
// Description : Shared widths, default geometry and FSM encoding for the
//               set-associative cache controller.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

    function automatic int age_width(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    localparam int ADDR_W_DEF     = 20;
    localparam int CPU_W_DEF      = 16;
    localparam int MEM_W_DEF      = 16;
    localparam int LINE_BYTES_DEF = 16;
    localparam int SETS_DEF       = 64;
    localparam int WAYS_DEF       = 2;

    localparam int OFF_W = $clog2(LINE_BYTES_DEF);
    localparam int IDX_W = $clog2(SETS_DEF);
    localparam int TAG_W = ADDR_W_DEF - OFF_W - IDX_W;
    localparam int BEATS = LINE_BYTES_DEF * 8 / MEM_W_DEF;
    localparam int AGE_W = age_width(WAYS_DEF);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOOKUP    = 3'd1,
        WB_CMD    = 3'd2,
        WB_DATA   = 3'd3,
        FILL_CMD  = 3'd4,
        FILL_DATA = 3'd5,
        RESP      = 3'd6
    } state_e;

endpackage
`default_nettype wire

// File: rtl/cache_lru_set.sv
`default_nettype none
// ============================================================================
// Module      : cache_lru_set
// Description : True-LRU age update and victim selection for one set.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_lru_set
    import cache_pkg::*;
#(
    parameter int WAYS     = WAYS_DEF,
    parameter int AGE_BITS = age_width(WAYS)
) (
    input  logic [WAYS*AGE_BITS-1:0] i_ages,
    input  logic [WAYS-1:0]          i_valids,
    input  logic [AGE_BITS-1:0]      i_hit_way,
    output logic [WAYS*AGE_BITS-1:0] o_ages,
    output logic [AGE_BITS-1:0]      o_victim
);

    logic [AGE_BITS-1:0] age_h;
    logic [AGE_BITS-1:0] age_w;
    logic                found;

    always_comb begin
        o_ages   = i_ages;
        o_victim = '0;
        found    = 1'b0;
        age_w    = '0;
        age_h    = i_ages[int'(i_hit_way)*AGE_BITS +: AGE_BITS];
        for (int w = 0; w < WAYS; w++) begin
            age_w = i_ages[w*AGE_BITS +: AGE_BITS];
            if (AGE_BITS'(w) == i_hit_way) begin
                o_ages[w*AGE_BITS +: AGE_BITS] = '0;
            end else if (age_w < age_h) begin
                o_ages[w*AGE_BITS +: AGE_BITS] = age_w + AGE_BITS'(1);
            end
        end
        // An empty way always wins over evicting a live line.
        for (int w = 0; w < WAYS; w++) begin
            if (!found && !i_valids[w]) begin
                o_victim = AGE_BITS'(w);
                found    = 1'b1;
            end
        end
        if (!found) begin
            for (int w = 0; w < WAYS; w++) begin
                if (i_ages[w*AGE_BITS +: AGE_BITS] == AGE_BITS'(WAYS-1)) begin
                    o_victim = AGE_BITS'(w);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cache_sa_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cache_sa_ctrl
// Description : N-way set-associative write-back, write-allocate cache
//               controller with true-LRU replacement.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_sa_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int CPU_W      = CPU_W_DEF,
    parameter int MEM_W      = MEM_W_DEF,
    parameter int LINE_BYTES = LINE_BYTES_DEF,
    parameter int SETS       = SETS_DEF,
    parameter int WAYS       = WAYS_DEF
) (
    input  logic                                   CLK,
    input  logic                                   RESET,
    input  logic                                   req_valid,
    output logic                                   req_ready,
    input  logic                                   req_we,
    input  logic [ADDR_W-1:0]                      req_addr,
    input  logic [CPU_W-1:0]                       req_wdata,
    output logic                                   resp_valid,
    output logic [CPU_W-1:0]                       resp_rdata,
    output logic                                   mem_cmd_valid,
    input  logic                                   mem_cmd_ready,
    output logic                                   mem_cmd_we,
    output logic [ADDR_W-$clog2(LINE_BYTES)-1:0]   mem_cmd_addr,
    output logic [MEM_W-1:0]                       mem_wdata,
    output logic                                   mem_wvalid,
    input  logic                                   mem_wready,
    input  logic [MEM_W-1:0]                       mem_rdata,
    input  logic                                   mem_rvalid
);

    localparam int OFF_BITS  = $clog2(LINE_BYTES);
    localparam int IDX_BITS  = $clog2(SETS);
    localparam int TAG_BITS  = ADDR_W - OFF_BITS - IDX_BITS;
    localparam int LINE_W    = LINE_BYTES * 8;
    localparam int NBEATS    = LINE_W / MEM_W;
    localparam int BEAT_BITS = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int WORD_OFF  = $clog2(CPU_W / 8);
    localparam int WSEL_BITS = OFF_BITS - WORD_OFF;
    localparam int AGE_BITS  = age_width(WAYS);

    state_e                    state_q, state_d;
    logic                      run_q, run_d;
    logic [BEAT_BITS-1:0]      beat_q, beat_d;
    logic [AGE_BITS-1:0]       victim_q, victim_d;
    logic                      req_we_q, req_we_d;
    logic [ADDR_W-1:0]         req_addr_q, req_addr_d;
    logic [CPU_W-1:0]          req_wdata_q, req_wdata_d;
    logic [CPU_W-1:0]          rdata_q, rdata_d;
    logic [LINE_W-1:0]         fill_q, fill_d;

    logic [LINE_W-1:0]         data_q  [WAYS][SETS];
    logic [TAG_BITS-1:0]       tag_q   [WAYS][SETS];
    logic [WAYS-1:0]           valid_q [SETS];
    logic [WAYS-1:0]           dirty_q [SETS];
    logic [WAYS*AGE_BITS-1:0]  age_q   [SETS];

    logic [IDX_BITS-1:0]       set_idx;
    logic [TAG_BITS-1:0]       req_tag;
    logic [WSEL_BITS-1:0]      wsel;
    logic                      hit;
    logic [AGE_BITS-1:0]       hit_way;
    logic [AGE_BITS-1:0]       lru_way;
    logic [AGE_BITS-1:0]       lru_victim;
    logic [WAYS*AGE_BITS-1:0]  lru_ages;
    logic                      line_we;
    logic [AGE_BITS-1:0]       line_way;
    logic [LINE_W-1:0]         line_wdata;
    logic                      line_dirty;
    logic                      age_we;
    logic                      unused_addr_bits;

    assign set_idx          = req_addr_q[OFF_BITS +: IDX_BITS];
    assign req_tag          = req_addr_q[ADDR_W-1 -: TAG_BITS];
    assign wsel             = req_addr_q[WORD_OFF +: WSEL_BITS];
    assign unused_addr_bits = ^req_addr_q;
    assign req_ready        = (state_q == IDLE) && run_q;

    function automatic logic [LINE_W-1:0] merge_word(
        input logic [LINE_W-1:0]    line,
        input logic [WSEL_BITS-1:0] sel,
        input logic [CPU_W-1:0]     word
    );
        logic [LINE_W-1:0] res;
        res = line;
        res[int'(sel)*CPU_W +: CPU_W] = word;
        return res;
    endfunction

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = WAYS-1; w >= 0; w--) begin
            if (valid_q[set_idx][w] && (tag_q[w][set_idx] == req_tag)) begin
                hit     = 1'b1;
                hit_way = AGE_BITS'(w);
            end
        end
    end

    // Ages are touched by the hit way in LOOKUP and by the refilled way at the end of a fill.
    assign lru_way = (state_q == FILL_DATA) ? victim_q : hit_way;

    cache_lru_set #(
        .WAYS     (WAYS),
        .AGE_BITS (AGE_BITS)
    ) u_lru (
        .i_ages    (age_q[set_idx]),
        .i_valids  (valid_q[set_idx]),
        .i_hit_way (lru_way),
        .o_ages    (lru_ages),
        .o_victim  (lru_victim)
    );

    always_comb begin
        state_d       = state_q;
        run_d         = 1'b1;
        beat_d        = beat_q;
        victim_d      = victim_q;
        req_we_d      = req_we_q;
        req_addr_d    = req_addr_q;
        req_wdata_d   = req_wdata_q;
        rdata_d       = rdata_q;
        fill_d        = fill_q;
        line_we       = 1'b0;
        line_way      = hit_way;
        line_wdata    = '0;
        line_dirty    = 1'b0;
        age_we        = 1'b0;
        resp_valid    = 1'b0;
        resp_rdata    = '0;
        mem_cmd_valid = 1'b0;
        mem_cmd_we    = 1'b0;
        mem_cmd_addr  = '0;
        mem_wvalid    = 1'b0;
        mem_wdata     = '0;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    req_we_d    = req_we;
                    req_addr_d  = req_addr;
                    req_wdata_d = req_wdata;
                    state_d     = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    age_we  = 1'b1;
                    rdata_d = req_we_q ? '0 : data_q[hit_way][set_idx][int'(wsel)*CPU_W +: CPU_W];
                    if (req_we_q) begin
                        line_we    = 1'b1;
                        line_dirty = 1'b1;
                        line_wdata = merge_word(data_q[hit_way][set_idx], wsel, req_wdata_q);
                    end
                    state_d = RESP;
                end else begin
                    victim_d = lru_victim;
                    beat_d   = '0;
                    if (valid_q[set_idx][lru_victim] && dirty_q[set_idx][lru_victim]) begin
                        state_d = WB_CMD;
                    end else begin
                        state_d = FILL_CMD;
                    end
                end
            end
            WB_CMD: begin
                mem_cmd_valid = 1'b1;
                mem_cmd_we    = 1'b1;
                mem_cmd_addr  = {tag_q[victim_q][set_idx], set_idx};
                if (mem_cmd_ready) begin
                    beat_d  = '0;
                    state_d = WB_DATA;
                end
            end
            WB_DATA: begin
                mem_wvalid = 1'b1;
                mem_wdata  = data_q[victim_q][set_idx][int'(beat_q)*MEM_W +: MEM_W];
                if (mem_wready) begin
                    if (beat_q == BEAT_BITS'(NBEATS-1)) begin
                        beat_d  = '0;
                        state_d = FILL_CMD;
                    end else begin
                        beat_d = beat_q + BEAT_BITS'(1);
                    end
                end
            end
            FILL_CMD: begin
                mem_cmd_valid = 1'b1;
                mem_cmd_addr  = {req_tag, set_idx};
                if (mem_cmd_ready) begin
                    beat_d  = '0;
                    state_d = FILL_DATA;
                end
            end
            FILL_DATA: begin
                if (mem_rvalid) begin
                    fill_d[int'(beat_q)*MEM_W +: MEM_W] = mem_rdata;
                    if (beat_q == BEAT_BITS'(NBEATS-1)) begin
                        line_we    = 1'b1;
                        line_way   = victim_q;
                        line_dirty = req_we_q;
                        line_wdata = req_we_q ? merge_word(fill_d, wsel, req_wdata_q) : fill_d;
                        age_we     = 1'b1;
                        rdata_d    = req_we_q ? '0 : fill_d[int'(wsel)*CPU_W +: CPU_W];
                        beat_d     = '0;
                        state_d    = RESP;
                    end else begin
                        beat_d = beat_q + BEAT_BITS'(1);
                    end
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_rdata = rdata_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q     <= IDLE;
            run_q       <= 1'b0;
            beat_q      <= '0;
            victim_q    <= '0;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            rdata_q     <= '0;
            fill_q      <= '0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            beat_q      <= beat_d;
            victim_q    <= victim_d;
            req_we_q    <= req_we_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            rdata_q     <= rdata_d;
            fill_q      <= fill_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    age_q[s][w*AGE_BITS +: AGE_BITS] <= AGE_BITS'(w);
                end
            end
        end else begin
            if (line_we) begin
                valid_q[set_idx][line_way] <= 1'b1;
                dirty_q[set_idx][line_way] <= line_dirty;
            end
            if (age_we) begin
                age_q[set_idx] <= lru_ages;
            end
        end
    end

    // Line payload and tags carry no reset; the valid bits gate their use.
    always_ff @(posedge CLK) begin
        if (line_we) begin
            data_q[line_way][set_idx] <= line_wdata;
            tag_q[line_way][set_idx]  <= req_tag;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_sa_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_sa_ctrl
// Description : Directed self-checking bench for cache_sa_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_sa_ctrl;

    logic        CLK;
    logic        RESET;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [19:0] req_addr;
    logic [15:0] req_wdata;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic        mem_cmd_valid;
    logic        mem_cmd_ready;
    logic        mem_cmd_we;
    logic [15:0] mem_cmd_addr;
    logic [15:0] mem_wdata;
    logic        mem_wvalid;
    logic        mem_wready;
    logic [15:0] mem_rdata;
    logic        mem_rvalid;

    int tests = 0;
    int fails = 0;

    cache_sa_ctrl dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .mem_cmd_valid (mem_cmd_valid),
        .mem_cmd_ready (mem_cmd_ready),
        .mem_cmd_we    (mem_cmd_we),
        .mem_cmd_addr  (mem_cmd_addr),
        .mem_wdata     (mem_wdata),
        .mem_wvalid    (mem_wvalid),
        .mem_wready    (mem_wready),
        .mem_rdata     (mem_rdata),
        .mem_rvalid    (mem_rvalid)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input string tag, input logic we, input logic [19:0] addr,
                         input logic [15:0] wdata);
        int n;
        n         = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        while (!req_ready && n < 50) begin
            step();
            n++;
        end
        check({tag, "_accept"}, req_ready, 1);
        step();
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_wdata = '0;
    endtask

    task automatic expect_cmd(input string tag, input logic we, input logic [15:0] addr);
        int n;
        n = 0;
        while (!mem_cmd_valid && n < 50) begin
            step();
            n++;
        end
        check({tag, "_cmd_valid"}, mem_cmd_valid, 1);
        check({tag, "_cmd_we"}, mem_cmd_we, we);
        check({tag, "_cmd_addr"}, mem_cmd_addr, addr);
        check({tag, "_busy"}, req_ready, 0);
        mem_cmd_ready = 1'b1;
        step();
        mem_cmd_ready = 1'b0;
    endtask

    task automatic send_fill(input logic [15:0] base);
        for (int i = 0; i < 8; i++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = base + 16'(i);
            step();
        end
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
    endtask

    initial begin
        logic [15:0] wb_exp [8];
        int          n;

        RESET         = 1'b0;
        req_valid     = 1'b0;
        req_we        = 1'b0;
        req_addr      = '0;
        req_wdata     = '0;
        mem_cmd_ready = 1'b0;
        mem_wready    = 1'b0;
        mem_rdata     = '0;
        mem_rvalid    = 1'b0;
        step();
        step();
        check("rst_req_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_cmd_valid", mem_cmd_valid, 0);
        check("rst_wvalid", mem_wvalid, 0);
        RESET = 1'b1;
        step();
        check("rst_release_ready", req_ready, 1);

        // Cold read, then a hit in the freshly filled line.
        issue("cold10", 1'b0, 20'h00010, 16'h0);
        expect_cmd("cold10", 1'b0, 16'h0001);
        send_fill(16'h1000);
        check("cold10_resp", resp_valid, 1);
        check("cold10_rdata", resp_rdata, 16'h1000);
        step();
        check("cold10_single", resp_valid, 0);

        issue("hit12", 1'b0, 20'h00012, 16'h0);
        check("hit12_lat1", resp_valid, 0);
        check("hit12_nocmd1", mem_cmd_valid, 0);
        step();
        check("hit12_resp", resp_valid, 1);
        check("hit12_rdata", resp_rdata, 16'h1001);
        check("hit12_nocmd2", mem_cmd_valid, 0);
        step();

        issue("wr12", 1'b1, 20'h00012, 16'hBEEF);
        step();
        check("wr12_resp", resp_valid, 1);
        check("wr12_rdata", resp_rdata, 16'h0000);
        check("wr12_nocmd", mem_cmd_valid, 0);
        step();

        // Second way of set 1 is empty: fill, no write-back.
        issue("rd410", 1'b0, 20'h00410, 16'h0);
        expect_cmd("rd410", 1'b0, 16'h0041);
        send_fill(16'h2000);
        check("rd410_rdata", resp_rdata, 16'h2000);
        step();

        // Dirty LRU victim with command and beat backpressure.
        issue("rd810", 1'b0, 20'h00810, 16'h0);
        n = 0;
        while (!mem_cmd_valid && n < 50) begin
            step();
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            check("bp_cmd_valid", mem_cmd_valid, 1);
            check("bp_cmd_we", mem_cmd_we, 1);
            check("bp_cmd_addr", mem_cmd_addr, 16'h0001);
            check("bp_cmd_busy", req_ready, 0);
            step();
        end
        mem_cmd_ready = 1'b1;
        step();
        mem_cmd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_wvalid", mem_wvalid, 1);
            check("bp_wdata", mem_wdata, 16'h1000);
            check("bp_w_busy", req_ready, 0);
            step();
        end
        wb_exp = '{16'h1000, 16'hBEEF, 16'h1002, 16'h1003,
                   16'h1004, 16'h1005, 16'h1006, 16'h1007};
        for (int i = 0; i < 8; i++) begin
            n = 0;
            while (!mem_wvalid && n < 50) begin
                step();
                n++;
            end
            check("wb_wvalid", mem_wvalid, 1);
            check($sformatf("wb_beat%0d", i), mem_wdata, wb_exp[i]);
            mem_wready = 1'b1;
            step();
            mem_wready = 1'b0;
        end
        expect_cmd("rd810", 1'b0, 16'h0081);
        send_fill(16'h3000);
        check("rd810_resp", resp_valid, 1);
        check("rd810_rdata", resp_rdata, 16'h3000);
        step();

        issue("hit410", 1'b0, 20'h00410, 16'h0);
        step();
        check("hit410_resp", resp_valid, 1);
        check("hit410_rdata", resp_rdata, 16'h2000);
        step();

        // LRU now points at the clean 0x810 line.
        issue("rdC10", 1'b0, 20'h00C10, 16'h0);
        expect_cmd("rdC10", 1'b0, 16'h00C1);
        send_fill(16'h4000);
        check("rdC10_rdata", resp_rdata, 16'h4000);
        step();

        // Reset in the middle of a fill burst.
        issue("rd1410", 1'b0, 20'h01410, 16'h0);
        expect_cmd("rd1410", 1'b0, 16'h0141);
        for (int i = 0; i < 3; i++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 16'h7000 + 16'(i);
            step();
        end
        mem_rdata = 16'h7003;
        RESET     = 1'b0;
        step();
        check("mid_rst_req_ready", req_ready, 0);
        check("mid_rst_resp_valid", resp_valid, 0);
        check("mid_rst_resp_rdata", resp_rdata, 0);
        check("mid_rst_cmd_valid", mem_cmd_valid, 0);
        check("mid_rst_cmd_we", mem_cmd_we, 0);
        check("mid_rst_cmd_addr", mem_cmd_addr, 0);
        check("mid_rst_wvalid", mem_wvalid, 0);
        check("mid_rst_wdata", mem_wdata, 0);
        RESET      = 1'b1;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        step();
        check("mid_rst_release", req_ready, 1);

        issue("post_rst10", 1'b0, 20'h00010, 16'h0);
        expect_cmd("post_rst10", 1'b0, 16'h0001);
        send_fill(16'h5000);
        check("post_rst10_rdata", resp_rdata, 16'h5000);
        step();

        // Request kept valid across a miss: second request accepted on first IDLE cycle.
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 20'h00020;
        step();
        req_addr = 20'h00022;
        check("held_busy", req_ready, 0);
        expect_cmd("held20", 1'b0, 16'h0002);
        send_fill(16'h6000);
        check("held_resp1", resp_valid, 1);
        check("held_rdata1", resp_rdata, 16'h6000);
        check("held_resp_busy", req_ready, 0);
        step();
        check("held_idle_ready", req_ready, 1);
        check("held_idle_noresp", resp_valid, 0);
        step();
        req_valid = 1'b0;
        check("held_lookup_busy", req_ready, 0);
        check("held_lookup_noresp", resp_valid, 0);
        step();
        check("held_resp2", resp_valid, 1);
        check("held_rdata2", resp_rdata, 16'h6001);
        step();
        check("held_after_resp2", resp_valid, 0);
        step();
        check("held_no_third", resp_valid, 0);
        check("held_no_cmd", mem_cmd_valid, 0);
        check("held_final_ready", req_ready, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cache_sa_ctrl.md
Name: cache_sa_ctrl

Overview:
- Parametrised N-way set-associative, write-back, write-allocate cache controller; successor to the fixed direct CPU/memory shared-bus cache model.
- Sits between the CPU port (valid/ready request, single-cycle response pulse) and main memory (command channel plus burst data beats).
- Adds configurable geometry, true-LRU replacement, dirty-line write-back and handshake backpressure on both sides.

Parameters:
- ADDR_W, 20, byte address width.
- CPU_W, 16, CPU word width in bits; power of 2, at least 8.
- MEM_W, 16, memory beat width in bits; divides LINE_BYTES*8.
- LINE_BYTES, 16, line size in bytes; power of 2.
- SETS, 64, number of sets; power of 2.
- WAYS, 2, associativity; power of 2, at least 1.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RESET  in  1  synchronous reset, active-low.
- req_valid  in  1  CPU request valid.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address; word-aligned, low log2(CPU_W/8) bits ignored.
- req_wdata  in  CPU_W  write data.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  CPU_W  read data (0 for writes).
- mem_cmd_valid  out  1  memory command valid.
- mem_cmd_ready  in  1  memory accepts command.
- mem_cmd_we  out  1  1 = write-back, 0 = fill.
- mem_cmd_addr  out  ADDR_W-OFF_W  line address.
- mem_wdata  out  MEM_W  write-back beat data.
- mem_wvalid  out  1  write-back beat valid.
- mem_wready  in  1  memory accepts the beat.
- mem_rdata  in  MEM_W  fill beat data.
- mem_rvalid  in  1  fill beat valid; always accepted, no backpressure.

Behaviour:
- Address split: OFF_W = log2(LINE_BYTES); IDX_W = log2(SETS); tag = remaining upper bits. BEATS = LINE_BYTES*8/MEM_W. Beats are sent and received lowest address first.
- Reset (RESET=0 sampled at an edge):
  - all valid and dirty bits cleared; way w age set to w.
  - FSM to IDLE; beat counter cleared.
  - every output 0 except req_ready, which is 1 from the first edge with RESET=1.
  - A reset mid-burst abandons the burst; the memory side resets together.
- FSM states and transitions:
  - IDLE: req_ready=1. On req_valid&&req_ready, latch the request and go to LOOKUP.
  - LOOKUP: tag compare over all ways.
    - Hit: update data/dirty on write, update LRU, go to RESP.
    - Miss, victim clean or invalid: go to FILL_CMD.
    - Miss, victim dirty: go to WB_CMD.
  - WB_CMD: assert mem_cmd_valid with we=1 and the victim line address; hold stable until mem_cmd_ready, then go to WB_DATA.
  - WB_DATA: present beat k with mem_wvalid=1; advance on mem_wready. After beat BEATS-1, go to FILL_CMD.
  - FILL_CMD: mem_cmd_valid with we=0; hold stable until ready, then go to FILL_DATA.
  - FILL_DATA: write each mem_rvalid beat into the victim way. After the last beat:
    - valid=1; dirty = req_we.
    - merge write data if a write.
    - update LRU; go to RESP.
  - RESP: resp_valid=1 for one cycle with resp_rdata, then go to IDLE.
- Latency:
  - Hit: resp_valid 2 cycles after the accept edge.
  - Miss: resp_valid the cycle after the edge that captures the last fill beat.
- req_ready=0 in every state except IDLE. A request held while busy is accepted on the first IDLE cycle.
- LRU: per-set age of log2(WAYS) bits per way; ages always form a permutation.
  - On access to way h: ages below age[h] increment, age[h]=0.
  - Victim: lowest-index invalid way; otherwise the way with age WAYS-1.
- mem_cmd_valid and mem_wvalid never drop before the handshake completes; payloads stay stable while valid.

Decomposition:
- Shared package cache_pkg:
  - derived widths: OFF_W, IDX_W, TAG_W, BEATS, AGE_W.
  - state enum (IDLE, LOOKUP, WB_CMD, WB_DATA, FILL_CMD, FILL_DATA, RESP).
  - default parameter constants.
- Sub-module cache_lru_set: per-set combinational age update and victim select (inputs: ages, valids, hit way).

Test Plan:
- Cold read 0x00010 -> FILL cmd addr 0x00001, fill beats 0x1000+i; resp_rdata=0x1000. Then read 0x00012 -> hit, rdata=0x1001, resp 2 cycles after accept, no mem_cmd_valid.
- Write 0x00012=0xBEEF (hit). Read 0x00410 -> fills way1, no write-back. Read 0x00810 -> WB cmd addr 0x00001, beat1=0xBEEF, then fill 0x00081.
- Read 0x00410 (hit), then 0x00C10 -> victim is the clean 0x00810 line, no write-back, fill 0x000C1.
- Hold mem_cmd_ready=0 and mem_wready=0 for 5 cycles -> cmd/beat valid and payload stable throughout, req_ready=0 throughout.
- RESET=0 during fill beat 3 -> all outputs 0 next cycle; a later read of 0x00010 misses.
- req_valid held during a miss -> accepted on the first IDLE cycle after resp_valid; exactly one response per request.
